cbus_arbiter: RTL
=================

CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 256, giving the maximum number of BUSY cycles allowed to wait for s_ready; the legal range is 2..65535.
REQ-002 The block SHALL have parameter ERR_RDATA, default 32'hDEADBEEF, giving the read data returned to a master on timeout.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 m0_valid, m0_addr, m0_wdata, m0_wstrb  input  1/32/32/4  master 0 (CPU) request in valid/ready bus protocol.
REQ-006 m0_ready, m0_rdata  output  1/32  master 0 response.
REQ-007 m1_valid, m1_addr, m1_wdata, m1_wstrb  input  1/32/32/4  master 1 (DMA/debug) request.
REQ-008 m1_ready, m1_rdata  output  1/32  master 1 response.
REQ-009 s_valid, s_addr, s_wdata, s_wstrb  output  1/32/32/4  request to the common bus decoder.
REQ-010 s_ready, s_rdata  input  1/32  common bus response.
REQ-011 grant  output  2  one-hot owner of the bus: 01 = m0, 10 = m1, 00 = none.
REQ-012 timeout_flag  output  1  sticky flag, set when a transaction times out.
REQ-013 timeout_clr  input  1  synchronous clear for timeout_flag.
REQ-014 err_count  output  8  count of timeouts, saturating.

Function
REQ-015 The block SHALL have three states: IDLE, BUSY and ERR.
REQ-016 IDLE arbitration:
  - If exactly one mX_valid is high, that master SHALL be granted.
  - If both are high, the master other than last_grant SHALL be granted (round-robin).
  - On a grant, the state SHALL become BUSY, grant SHALL register the winner, and the timeout counter SHALL clear.
REQ-017 In BUSY, s_valid SHALL be 1, and s_addr, s_wdata and s_wstrb SHALL pass combinationally from the granted master.
REQ-018 Outside BUSY, s_valid, s_addr, s_wdata and s_wstrb SHALL be 0.
REQ-019 Latency: a request sampled in cycle N SHALL produce s_valid in cycle N+1.
REQ-020 In BUSY with s_ready=1, the block SHALL, in the same cycle:
  - assert ready to the granted master;
  - pass s_rdata to that master's rdata.
  On the next edge it SHALL go to IDLE, set last_grant to the granted master, and set grant to 00.
REQ-021 The non-granted master SHALL see ready=0 and rdata=0 at all times.
REQ-022 mX_rdata SHALL be 0 whenever mX_ready=0.
REQ-023 The timeout counter SHALL be 16 bits and SHALL increment every BUSY cycle with s_ready=0.
REQ-024 When the counter equals TIMEOUT_CYCLES-1 and s_ready=0, the state SHALL become ERR on the next edge.
REQ-025 In ERR, the block SHALL:
  - hold s_valid=0;
  - pulse the granted master's ready for exactly one cycle, with rdata=ERR_RDATA;
  - set timeout_flag;
  - increment err_count, saturating at 255;
  - go to IDLE on the next edge, updating last_grant as in REQ-020.
REQ-026 If the granted master drops valid in BUSY before s_ready, the transfer SHALL be aborted:
  - no ready SHALL be issued to that master;
  - the state SHALL become IDLE on the next edge;
  - last_grant SHALL be unchanged.
REQ-027 If s_ready and the timeout terminal count occur in the same cycle, s_ready SHALL win: normal completion, no error.
REQ-028 timeout_flag set and timeout_clr asserted in the same cycle SHALL leave timeout_flag set.
REQ-029 The minimum gap between two granted transactions SHALL be one IDLE cycle.
REQ-030 s_ready seen outside BUSY SHALL be ignored.

Reset
REQ-031 While resetn=0, the block SHALL asynchronously force:
  - state to IDLE and grant to 00;
  - last_grant to m1, so m0 wins the first tie;
  - timeout counter, timeout_flag and err_count to 0;
  - all outputs to 0.
REQ-032 A reset asserted mid-transaction SHALL abort that transaction without issuing mX_ready.
REQ-033 After resetn rises, arbitration SHALL start from the first rising edge of clk.

Verification
REQ-034 m0 read of 0x10000000, s_ready one cycle after s_valid with s_rdata=0x12345678 -> grant=01, m0_ready for 1 cycle with m0_rdata=0x12345678, m1_ready=0.
REQ-035 Both masters valid from reset -> m0 granted first, then m1, then m0 again when both remain valid.
REQ-036 m1 request with s_ready never asserted, TIMEOUT_CYCLES=4 -> s_valid high for 4 cycles, then m1_ready with m1_rdata=0xDEADBEEF, timeout_flag=1, err_count=1.
REQ-037 300 consecutive timeouts -> err_count=255; pulse timeout_clr -> timeout_flag=0, err_count stays 255.
REQ-038 resetn pulsed low while in BUSY -> s_valid, grant and mX_ready go to 0 immediately; after release a new m0 request completes normally.
REQ-039 s_ready in the same cycle as the counter reaching TIMEOUT_CYCLES-1 -> normal completion with s_rdata, timeout_flag stays 0.

Source files
------------

// File: rtl/cbus_arbiter_if.sv
// Bus bundle for the two-master arbiter: two request/response master ports and
// the shared request/response port towards the common bus decoder.
interface cbus_arbiter_if;
    logic        m0_valid;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;

    logic        m1_valid;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic [31:0] m1_rdata;

    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    // slave: the arbiter's view (serves both masters, drives the shared bus)
    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m0_ready, m0_rdata,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output m1_ready, m1_rdata,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata
    );

    // master: the surrounding system's view (masters plus bus decoder)
    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m0_ready, m0_rdata,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  m1_ready, m1_rdata,
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );
endinterface

// File: rtl/cbus_arbiter.sv
// Two-master round-robin arbiter onto a single valid/ready bus, with a per-
// transaction timeout that answers the stalled master with ERR_RDATA.
module cbus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              resetn,
    cbus_arbiter_if.slave     bus,
    output logic [1:0]        grant,
    output logic              timeout_flag,
    input  logic              timeout_clr,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [15:0] TERMINAL = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [1:0]  grant_reg, grant_next;
    logic        last_grant_reg, last_grant_next;   // 1 = m1 was last served
    logic [15:0] cnt_reg, cnt_next;
    logic        flag_reg, flag_next;
    logic [7:0]  err_cnt_reg, err_cnt_next;

    logic        timeout_hit;
    logic        busy;
    logic        in_err;
    logic        sel;
    logic        sel_valid;
    logic        pick_m1;

    logic [1:0]  req_valid;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata [2];

    assign req_valid    = {bus.m1_valid, bus.m0_valid};
    assign req_addr[0]  = bus.m0_addr;
    assign req_addr[1]  = bus.m1_addr;
    assign req_wdata[0] = bus.m0_wdata;
    assign req_wdata[1] = bus.m1_wdata;
    assign req_wstrb[0] = bus.m0_wstrb;
    assign req_wstrb[1] = bus.m1_wstrb;

    assign busy      = (state_reg == BUSY);
    assign in_err    = (state_reg == ERR);
    assign sel       = grant_reg[1];
    assign sel_valid = req_valid[sel];

    // On a tie the master that was not served last wins.
    assign pick_m1 = (req_valid == 2'b10) || ((req_valid == 2'b11) && !last_grant_reg);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            grant_reg      <= 2'b00;
            last_grant_reg <= 1'b1;
            cnt_reg        <= 16'd0;
            flag_reg       <= 1'b0;
            err_cnt_reg    <= 8'd0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            cnt_reg        <= cnt_next;
            flag_reg       <= flag_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        cnt_next        = cnt_reg;
        timeout_hit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    state_next = BUSY;
                    grant_next = pick_m1 ? 2'b10 : 2'b01;
                    cnt_next   = 16'd0;
                end
            end
            BUSY: begin
                // A master withdrawing its request abandons the transfer
                // silently and does not count as having been served.
                if (!sel_valid) begin
                    state_next = IDLE;
                    grant_next = 2'b00;
                end else if (bus.s_ready) begin
                    state_next      = IDLE;
                    grant_next      = 2'b00;
                    last_grant_next = sel;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                    if (cnt_reg == TERMINAL) begin
                        state_next  = ERR;
                        timeout_hit = 1'b1;
                    end
                end
            end
            ERR: begin
                state_next      = IDLE;
                grant_next      = 2'b00;
                last_grant_next = sel;
            end
            default: begin
                state_next = IDLE;
                grant_next = 2'b00;
            end
        endcase
    end

    // Flag and counter update on entry to ERR so they are already visible
    // during the error response cycle; a set beats a simultaneous clear.
    always_comb begin
        flag_next    = flag_reg;
        err_cnt_next = err_cnt_reg;
        if (timeout_hit) begin
            flag_next = 1'b1;
            if (err_cnt_reg != 8'hFF) begin
                err_cnt_next = err_cnt_reg + 8'd1;
            end
        end else if (timeout_clr) begin
            flag_next = 1'b0;
        end
    end

    always_comb begin
        bus.s_valid = 1'b0;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        bus.s_wstrb = '0;
        if (busy) begin
            bus.s_valid = 1'b1;
            bus.s_addr  = req_addr[sel];
            bus.s_wdata = req_wdata[sel];
            bus.s_wstrb = req_wstrb[sel];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            assign rsp_ready[gi] = grant_reg[gi] &&
                                   (in_err || (busy && req_valid[gi] && bus.s_ready));
            assign rsp_rdata[gi] = rsp_ready[gi] ? (in_err ? ERR_RDATA : bus.s_rdata) : '0;
        end
    endgenerate

    assign bus.m0_ready = rsp_ready[0];
    assign bus.m0_rdata = rsp_rdata[0];
    assign bus.m1_ready = rsp_ready[1];
    assign bus.m1_rdata = rsp_rdata[1];

    assign grant        = grant_reg;
    assign timeout_flag = flag_reg;
    assign err_count    = err_cnt_reg;

endmodule
